// File: rtl/hyperbus_pkg.sv
// Shared definitions for the HyperBus controller.
// Holds the one-hot FSM state encoding, the bit positions of the 48-bit
// command/address (CA) word, the bounds on initial access latency and the
// packed payload captured when a request is accepted.
package hyperbus_pkg;

  // One-hot controller states
  typedef enum logic [4:0] {
    ST_IDLE = 5'b00001,
    ST_CA   = 5'b00010,
    ST_LAT  = 5'b00100,
    ST_XFER = 5'b01000,
    ST_END  = 5'b10000
  } state_e;

  // CA word layout
  localparam int unsigned CA_WIDTH     = 48;
  localparam int unsigned CA_WORDS     = 3;
  localparam int unsigned CA_RW_BIT    = 47;
  localparam int unsigned CA_AS_BIT    = 46;
  localparam int unsigned CA_BURST_BIT = 45;
  localparam int unsigned CA_ROW_HI    = 44;
  localparam int unsigned CA_ROW_LO    = 16;
  localparam int unsigned CA_COL_HI    = 2;

  // Legal initial latency range in clocks
  localparam int unsigned LAT_MIN = 4;
  localparam int unsigned LAT_MAX = 16;

  // Request payload registered at acceptance
  typedef struct packed {
    logic                rd;
    logic [CA_WIDTH-1:0] ca;
    logic [15:0]         dat;
    logic [1:0]          mask;
  } xfer_t;

  // Force a configured latency into the legal range
  function automatic int unsigned lat_clamp(input int unsigned lat);
    if (lat < LAT_MIN) return LAT_MIN;
    if (lat > LAT_MAX) return LAT_MAX;
    return lat;
  endfunction

  // Clocks spent in LAT after the three CA clocks
  function automatic int unsigned lat_wait(input int unsigned lat, input logic dbl);
    return dbl ? (2 * lat - 3) : (lat - 3);
  endfunction

endpackage

// File: rtl/hyperbus_ca_gen.sv
// Builds the 48-bit HyperBus command/address word from a byte address.
// Ports:
//   adr  in  HBUS_ADDR_WIDTH  request byte address
//   rd   in  1                1 = read transaction
//   ca   out 48               CA word (combinational)
module hyperbus_ca_gen
  import hyperbus_pkg::*;
#(
  parameter int unsigned HBUS_ADDR_WIDTH = 32
) (
  input  logic [HBUS_ADDR_WIDTH-1:0] adr,
  input  logic                       rd,
  output logic [CA_WIDTH-1:0]        ca
);

  logic [31:0] wa;

  // Word address split into row/upper-column and lower-column fields
  always_comb begin
    wa                      = 32'(adr >> 1);
    ca                      = '0;
    ca[CA_RW_BIT]           = rd;
    ca[CA_AS_BIT]           = 1'b0;
    ca[CA_BURST_BIT]        = 1'b1;
    ca[CA_ROW_HI:CA_ROW_LO] = wa[31:3];
    ca[CA_COL_HI:0]         = wa[2:0];
  end

endmodule

// File: rtl/hyperbus_ctrl.sv
// HyperBus single-word controller: accepts one read or write request at a
// time, issues the CA phase, waits the initial latency and performs a
// single 16-bit transfer. DDR I/O cells live outside this block; each
// clock here carries one CK worth of data (both edges).
// Optional feature: define HBUS_VARIABLE_LATENCY_EN to let the device
// select doubled latency through RWDS during CA; otherwise latency is
// always doubled.
// Ports:
//   hbus_clk, hbus_rst            clock, synchronous active-high reset
//   hbus_adr_i/dat_i/mask_i       request address, write data, byte mask
//   hbus_rrq, hbus_wrq            read / write request (write wins)
//   hbus_ready                    idle, request may be issued
//   hbus_valid/dat_o/err          read completion pulse, data, timeout flag
//   hbus_cs_n, hbus_ck_en         chip select, PHY clock enable
//   hbus_dq_o/oe, hbus_dq_i       DQ word out/enable, captured DQ word
//   hbus_rwds_o/oe, hbus_rwds_i   RWDS per edge out/enable, captured RWDS
module hyperbus_ctrl
  import hyperbus_pkg::*;
#(
  parameter int unsigned HBUS_ADDR_WIDTH = 32,
  parameter int unsigned HBUS_DATA_WIDTH = 16,
  parameter int unsigned LATENCY         = 6,
  parameter int unsigned READ_TIMEOUT    = 64
) (
  input  logic                       hbus_clk,
  input  logic                       hbus_rst,
  input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
  input  logic [1:0]                 hbus_mask_i,
  input  logic                       hbus_rrq,
  input  logic                       hbus_wrq,
  output logic                       hbus_ready,
  output logic                       hbus_valid,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
  output logic                       hbus_err,
  output logic                       hbus_cs_n,
  output logic                       hbus_ck_en,
  output logic [HBUS_DATA_WIDTH-1:0] hbus_dq_o,
  output logic                       hbus_dq_oe,
  input  logic [HBUS_DATA_WIDTH-1:0] hbus_dq_i,
  output logic [1:0]                 hbus_rwds_o,
  output logic                       hbus_rwds_oe,
  input  logic [1:0]                 hbus_rwds_i
);

  localparam int unsigned LAT_EFF  = lat_clamp(LATENCY);
  localparam int unsigned WAIT_DBL = lat_wait(LAT_EFF, 1'b1);
  localparam int unsigned WAIT_SGL = lat_wait(LAT_EFF, 1'b0);
  localparam int unsigned TIMEOUT  = (READ_TIMEOUT < 1) ? 1 : READ_TIMEOUT;
  localparam int unsigned CNT_MAX  = (TIMEOUT > 2 * LAT_MAX) ? TIMEOUT : 2 * LAT_MAX;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 1);

  state_e                state;
  state_e                state_nxt;
  logic [CNT_W-1:0]      cnt;
  xfer_t                 xfer;
  xfer_t                 xfer_new;
  logic [CA_WIDTH-1:0]   ca_new;
  logic [15:0]           ca_word;
  logic                  req;
  logic                  rwds_any;
  logic                  ca_last;
  logic                  lat_last;
  logic                  rd_timeout;
  logic                  dbl;

  hyperbus_ca_gen #(
    .HBUS_ADDR_WIDTH(HBUS_ADDR_WIDTH)
  ) u_ca_gen (
    .adr(hbus_adr_i),
    .rd (hbus_rrq & ~hbus_wrq),
    .ca (ca_new)
  );

  assign req        = hbus_rrq | hbus_wrq;
  assign rwds_any   = |hbus_rwds_i;
  assign ca_last    = (cnt == CNT_W'(CA_WORDS - 1));
  assign lat_last   = dbl ? (cnt == CNT_W'(WAIT_DBL - 1)) : (cnt == CNT_W'(WAIT_SGL - 1));
  assign rd_timeout = (cnt == CNT_W'(TIMEOUT - 1));

  // Payload snapshot; a simultaneous write request overrides the read
  always_comb begin
    xfer_new      = '0;
    xfer_new.rd   = hbus_rrq & ~hbus_wrq;
    xfer_new.ca   = ca_new;
    xfer_new.dat  = 16'(hbus_dat_i);
    xfer_new.mask = hbus_mask_i;
  end

`ifdef HBUS_VARIABLE_LATENCY_EN
  // Device requests doubled latency by driving RWDS high in any CA clock
  always_ff @(posedge hbus_clk) begin
    if (hbus_rst) begin
      dbl <= 1'b0;
    end else if (state == ST_IDLE) begin
      dbl <= 1'b0;
    end else if (state == ST_CA) begin
      dbl <= dbl | rwds_any;
    end
  end
`else
  assign dbl = 1'b1;
`endif

  // State register
  always_ff @(posedge hbus_clk) begin
    if (hbus_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (req) state_nxt = ST_CA;
      ST_CA:   if (ca_last) state_nxt = ST_LAT;
      ST_LAT:  if (lat_last) state_nxt = ST_XFER;
      ST_XFER: if (!xfer.rd || rwds_any || rd_timeout) state_nxt = ST_END;
      ST_END:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Phase counter, request capture and read completion
  always_ff @(posedge hbus_clk) begin
    if (hbus_rst) begin
      cnt        <= '0;
      xfer       <= '0;
      hbus_valid <= 1'b0;
      hbus_err   <= 1'b0;
      hbus_dat_o <= '0;
    end else begin
      hbus_valid <= 1'b0;
      hbus_err   <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (req) xfer <= xfer_new;
        end
        ST_CA:  cnt <= ca_last ? '0 : cnt + CNT_W'(1);
        ST_LAT: cnt <= lat_last ? '0 : cnt + CNT_W'(1);
        ST_XFER: begin
          cnt <= cnt + CNT_W'(1);
          if (xfer.rd) begin
            if (rwds_any) begin
              hbus_valid <= 1'b1;
              hbus_dat_o <= hbus_dq_i;
            end else if (rd_timeout) begin
              hbus_valid <= 1'b1;
              hbus_err   <= 1'b1;
              hbus_dat_o <= '0;
            end
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // CA word for the current CA clock
  always_comb begin
    ca_word = xfer.ca[15:0];
    if (cnt == '0) begin
      ca_word = xfer.ca[47:32];
    end else if (cnt == CNT_W'(1)) begin
      ca_word = xfer.ca[31:16];
    end
  end

  // Bus outputs decoded from the state register
  always_comb begin
    hbus_ready   = 1'b0;
    hbus_cs_n    = 1'b1;
    hbus_ck_en   = 1'b0;
    hbus_dq_o    = '0;
    hbus_dq_oe   = 1'b0;
    hbus_rwds_o  = '0;
    hbus_rwds_oe = 1'b0;
    unique case (state)
      ST_IDLE: hbus_ready = 1'b1;
      ST_CA: begin
        hbus_cs_n  = 1'b0;
        hbus_ck_en = 1'b1;
        hbus_dq_oe = 1'b1;
        hbus_dq_o  = HBUS_DATA_WIDTH'(ca_word);
      end
      ST_LAT: begin
        hbus_cs_n  = 1'b0;
        hbus_ck_en = 1'b1;
      end
      ST_XFER: begin
        hbus_cs_n  = 1'b0;
        hbus_ck_en = 1'b1;
        if (!xfer.rd) begin
          hbus_dq_o    = HBUS_DATA_WIDTH'(xfer.dat);
          hbus_rwds_o  = xfer.mask;
          hbus_dq_oe   = 1'b1;
          hbus_rwds_oe = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_hyperbus_ctrl.sv
// Scoreboard bench for hyperbus_ctrl: a driver issues randomized requests and
// plays the device side, pushing expected bus transactions into a queue;
// a monitor reconstructs each chip-select window and the read completion
// and compares against the queue.
module tb_hyperbus_ctrl;

  localparam int unsigned LAT = 6;
  localparam int unsigned TO  = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr_i;
  logic [15:0] dat_i;
  logic [1:0]  mask_i;
  logic        rrq;
  logic        wrq;
  logic        ready;
  logic        valid;
  logic [15:0] dat_o;
  logic        err;
  logic        cs_n;
  logic        ck_en;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic [15:0] dq_i;
  logic [1:0]  rwds_o;
  logic        rwds_oe;
  logic [1:0]  rwds_i;

  hyperbus_ctrl #(
    .HBUS_ADDR_WIDTH(32),
    .HBUS_DATA_WIDTH(16),
    .LATENCY        (LAT),
    .READ_TIMEOUT   (TO)
  ) dut (
    .hbus_clk    (clk),
    .hbus_rst    (rst),
    .hbus_adr_i  (adr_i),
    .hbus_dat_i  (dat_i),
    .hbus_mask_i (mask_i),
    .hbus_rrq    (rrq),
    .hbus_wrq    (wrq),
    .hbus_ready  (ready),
    .hbus_valid  (valid),
    .hbus_dat_o  (dat_o),
    .hbus_err    (err),
    .hbus_cs_n   (cs_n),
    .hbus_ck_en  (ck_en),
    .hbus_dq_o   (dq_o),
    .hbus_dq_oe  (dq_oe),
    .hbus_dq_i   (dq_i),
    .hbus_rwds_o (rwds_o),
    .hbus_rwds_oe(rwds_oe),
    .hbus_rwds_i (rwds_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] ca0;
    logic [15:0] ca1;
    logic [15:0] ca2;
    int          len;
    bit          wr;
    logic [15:0] wdat;
    logic [1:0]  wmask;
    bit          vld;
    logic [15:0] rdat;
    bit          err;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  bit   abort_pend = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int lat_w(input bit dbl);
    return dbl ? (2 * LAT - 3) : (LAT - 3);
  endfunction

  // Expected bus transaction from the protocol rules
  function automatic exp_t model(input bit rd, input bit wr, input logic [31:0] adr,
                                 input logic [15:0] dat, input logic [1:0] mask,
                                 input int d, input logic [15:0] dq, input bit dbl);
    exp_t        e;
    int unsigned wa;
    bit          is_wr;
    is_wr   = wr;
    wa      = adr / 2;
    e.ca0   = 16'(((rd && !is_wr) ? 32'h8000 : 32'h0) + 32'h2000 + ((wa / (1 << 19)) % (1 << 13)));
    e.ca1   = 16'((wa / 8) % 65536);
    e.ca2   = 16'(wa % 8);
    e.len   = 3 + lat_w(dbl) + (is_wr ? 1 : ((d < int'(TO)) ? d + 1 : int'(TO)));
    e.wr    = is_wr;
    e.wdat  = dat;
    e.wmask = mask;
    e.vld   = !is_wr;
    e.err   = !is_wr && (d >= int'(TO));
    e.rdat  = (d < int'(TO)) ? dq : 16'h0;
    return e;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    @(negedge clk);
    while (!ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("wait_ready", ready, 1'b1);
  endtask

  // car holds the RWDS value driven in each of the three CA clocks
  // (bits 1:0 first); d is the XFER clock carrying the read strobe
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] adr,
                         input logic [15:0] dat, input logic [1:0] mask,
                         input int d, input logic [15:0] dq, input logic [5:0] car);
    exp_t e;
    bit   dbl;
    int   w;
    int   kend;
    int   kstb;
`ifdef HBUS_VARIABLE_LATENCY_EN
    dbl = (car != 6'b0);
`else
    dbl = 1'b1;
`endif
    w    = lat_w(dbl);
    kstb = 4 + w + d;
    kend = wr ? 4 : 4 + w + ((d < int'(TO)) ? d + 1 : int'(TO));
    wait_ready();
    e = model(rd, wr, adr, dat, mask, d, dq, dbl);
    sbq.push_back(e);
    rrq = rd; wrq = wr; adr_i = adr; dat_i = dat; mask_i = mask;
    @(negedge clk);
    rrq = 1'b0; wrq = 1'b0;
    adr_i = $urandom; dat_i = 16'($urandom); mask_i = 2'($urandom);
    for (int k = 1; k <= kend; k++) begin
      if (k > 1) @(negedge clk);
      dq_i   = 16'($urandom);
      rwds_i = (k <= 3) ? car[2*(k-1) +: 2] : 2'b00;
      if (!wr && d < int'(TO) && k == kstb) begin
        rwds_i = 2'($urandom_range(1, 3));
        dq_i   = dq;
      end
    end
    rwds_i = 2'b00;
  endtask

  // Read aborted by reset while in latency
  task automatic abort_txn();
    wait_ready();
    rrq = 1'b1; adr_i = $urandom;
    @(negedge clk);
    rrq = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_in_lat_cs", cs_n, 1'b0);
    abort_pend = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", cs_n, 1'b1);
    chk("abort_ck_en", ck_en, 1'b0);
    chk("abort_oe", {dq_oe, rwds_oe}, 2'b00);
    chk("abort_valid", {valid, err}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", ready, 1'b1);
  endtask

  // Monitor: rebuilds each chip-select window and checks it on release
  initial begin : mon
    int          run;
    bit          prev;
    bit          boundary;
    bit          ca_oe_ok;
    bit          wb;
    bit          wb_oe;
    logic [15:0] cao0, cao1, cao2, wbd;
    logic [1:0]  wbm;
    exp_t        e;
    run = 0; prev = 1'b1; wb = 1'b0; ca_oe_ok = 1'b1; wb_oe = 1'b0;
    cao0 = '0; cao1 = '0; cao2 = '0; wbd = '0; wbm = '0;
    forever begin
      @(negedge clk);
      boundary = (cs_n === 1'b1) && !prev;
      if (cs_n === 1'b0) begin
        if (run == 0) cao0 = dq_o;
        if (run == 1) cao1 = dq_o;
        if (run == 2) cao2 = dq_o;
        if (run < 3) ca_oe_ok = ca_oe_ok && dq_oe && !rwds_oe;
        else if (dq_oe || rwds_oe) begin
          wb = 1'b1; wbd = dq_o; wbm = rwds_o; wb_oe = dq_oe && rwds_oe;
        end
        run++;
      end else if (boundary) begin
        if (abort_pend) begin
          abort_pend = 1'b0;
        end else if (sbq.size() == 0) begin
          chk("unexpected_window", 1'b1, 1'b0);
        end else begin
          e = sbq.pop_front();
          chk("ca_word0", cao0, e.ca0);
          chk("ca_word1", cao1, e.ca1);
          chk("ca_word2", cao2, e.ca2);
          chk("ca_oe", ca_oe_ok, 1'b1);
          chk("cs_window_len", run, e.len);
          chk("write_beat_seen", wb, e.wr);
          if (e.wr) begin
            chk("write_dq", wbd, e.wdat);
            chk("write_rwds", wbm, e.wmask);
            chk("write_oe", wb_oe, 1'b1);
          end
          chk("end_valid", valid, e.vld);
          chk("end_ready", ready, 1'b0);
          chk("end_ck_en", ck_en, 1'b0);
          if (e.vld) begin
            chk("read_err", err, e.err);
            chk("read_dat", dat_o, e.rdat);
          end
        end
        run = 0; wb = 1'b0; ca_oe_ok = 1'b1;
      end
      if (!boundary && (valid === 1'b1 || err === 1'b1)) chk("spurious_valid", {valid, err}, 2'b00);
      prev = (cs_n !== 1'b0);
    end
  end

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, %0d checks", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          r;
    int          d;
    logic [5:0]  car;
    rst = 1'b1; rrq = 1'b0; wrq = 1'b0; adr_i = '0; dat_i = '0; mask_i = '0;
    dq_i = '0; rwds_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", ready, 1'b1);
    chk("rst_cs_n", cs_n, 1'b1);
    chk("rst_ck_en", ck_en, 1'b0);
    chk("rst_oe", {dq_oe, rwds_oe}, 2'b00);
    chk("rst_valid_err", {valid, err}, 2'b00);
    chk("rst_dat_o", dat_o, 16'h0);
    chk("rst_dq_rwds", {dq_o, rwds_o}, 18'h0);

    run_txn(1'b0, 1'b1, 32'h0000_1234, 16'hA5A5, 2'b00, 0, 16'h0, 6'b000000);
    run_txn(1'b1, 1'b0, 32'h0000_0010, 16'h0, 2'b00, 2, 16'hBEEF, 6'b000000);
    run_txn(1'b1, 1'b0, 32'h0000_0200, 16'h0, 2'b00, int'(TO), 16'h0, 6'b000000);
    run_txn(1'b1, 1'b1, 32'h0000_0456, 16'h5A5A, 2'b10, 0, 16'h0, 6'b000000);
    run_txn(1'b1, 1'b0, 32'h0000_0040, 16'h0, 2'b00, 0, 16'h1357, 6'b000001);
    run_txn(1'b0, 1'b1, 32'hFFFF_FFFE, 16'hFFFF, 2'b01, 0, 16'h0, 6'b100000);
    run_txn(1'b1, 1'b0, 32'h0000_0020, 16'h0, 2'b00, int'(TO) - 1, 16'h2468, 6'b000000);
    abort_txn();
    run_txn(1'b1, 1'b0, 32'h0000_0010, 16'h0, 2'b00, 1, 16'hCAFE, 6'b000000);

    for (int i = 0; i < 40; i++) begin
      r   = $urandom_range(0, 4);
      d   = $urandom_range(0, TO + 2);
      car = ($urandom_range(0, 1) == 1) ? 6'($urandom) : 6'b0;
      run_txn(r <= 1, r >= 1, $urandom, 16'($urandom), 2'($urandom), d, 16'($urandom), car);
    end

    for (int n = 0; n < 300 && sbq.size() != 0; n++) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hyperbus_ctrl.md
HYPERBUS_CTRL -- requirements
Module: hyperbus_ctrl

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  HBUS_ADDR_WIDTH, 32, byte address width of requests.
  HBUS_DATA_WIDTH, 16, request data width; fixed at 16.
  LATENCY, 6, initial access latency in clocks; legal range 4..16.
  READ_TIMEOUT, 64, clocks to wait for read strobe before error.
REQ-002 Ports, one per line: name, direction, width, meaning.
  hbus_clk  in  1  sole clock.
  hbus_rst  in  1  reset.
  hbus_adr_i  in  HBUS_ADDR_WIDTH  request byte address.
  hbus_dat_i  in  16  write data.
  hbus_mask_i  in  2  write byte mask, 1 = byte not written.
  hbus_rrq  in  1  read request.
  hbus_wrq  in  1  write request.
  hbus_ready  out  1  idle; can accept a request.
  hbus_valid  out  1  read data valid, one-cycle pulse.
  hbus_dat_o  out  16  read data.
  hbus_err  out  1  read timeout, pulses with hbus_valid.
  hbus_cs_n  out  1  chip select, active low.
  hbus_ck_en  out  1  PHY clock enable.
  hbus_dq_o  out  16  DQ word, both edges of one CK.
  hbus_dq_oe  out  1  DQ output enable.
  hbus_dq_i  in  16  DQ word captured by PHY.
  hbus_rwds_o  out  2  RWDS per edge.
  hbus_rwds_oe  out  1  RWDS output enable.
  hbus_rwds_i  in  2  RWDS captured by PHY.
REQ-003 Single clock hbus_clk; hbus_rst is synchronous and active-high.

Function
REQ-004 States SHALL be IDLE, CA, LAT, XFER, END, one-hot.
REQ-005 hbus_ready SHALL be 1 only in IDLE; a request is accepted when hbus_rrq or hbus_wrq is 1 while hbus_ready is 1.
REQ-006 If hbus_rrq and hbus_wrq are both 1 at acceptance, the write SHALL be performed and the read dropped.
REQ-007 Address, data and mask SHALL be registered at acceptance; later input changes have no effect.
REQ-008 Word address wa = adr>>1; CA[47] = read, CA[46] = 0, CA[45] = 1, CA[44:16] = wa[31:3], CA[15:3] = 0, CA[2:0] = wa[2:0].
REQ-009 CA lasts 3 clocks driving CA[47:32], CA[31:16], CA[15:0]; cs_n = 0, ck_en = 1, dq_oe = 1, rwds_oe = 0.
REQ-010 LAT SHALL last W clocks, dq_oe = 0. W = 2*LATENCY-3 when latency is doubled, else LATENCY-3.
REQ-011 Write XFER is 1 clock: dq_o = data, rwds_o = mask, dq_oe = rwds_oe = 1.
REQ-012 Read XFER holds until hbus_rwds_i != 0; on that clock, dat_o is captured from dq_i and hbus_valid pulses the next cycle.
REQ-013 If READ_TIMEOUT clocks pass in read XFER with no strobe, hbus_valid and hbus_err SHALL pulse together with hbus_dat_o = 0.
REQ-014 END is 1 clock with cs_n = 1, ck_en = 0, all oe = 0; then IDLE.
REQ-015 Outside CA/LAT/XFER: cs_n = 1, ck_en = 0, dq_oe = rwds_oe = 0, dq_o = 0, rwds_o = 0.

Reset
REQ-016 On hbus_rst: state IDLE, cs_n = 1, ck_en = 0, all oe = 0, valid = err = 0, dat_o = 0, counters 0; ready = 1 the cycle after release.
REQ-017 Reset during any transaction aborts it with no valid/err pulse.

Configuration
REQ-018 With HBUS_VARIABLE_LATENCY_EN defined, latency is doubled iff any hbus_rwds_i bit is 1 during any CA clock. Without it, latency is always doubled and hbus_rwds_i is ignored during CA.

Structure
REQ-019 Package hyperbus_pkg: state encodings, CA bit-position constants, latency bound constants.
REQ-020 Optional sub-module hyperbus_ca_gen: builds the 48-bit CA from address and direction. DDR I/O is external.

Verification (LATENCY = 6, no macro unless stated)
REQ-021 Write adr 0x00001234, dat 0xA5A5, mask 00 -> CA words 0x2000, 0x0123, 0x0002; 9 LAT clocks; dq_o = 0xA5A5 with rwds_o = 00; END; ready.
REQ-022 Read adr 0x00000010, rwds_i = 11 with dq_i = 0xBEEF 2 clocks into XFER -> CA words 0xA000, 0x0001, 0x0000; valid pulse with dat_o = 0xBEEF, err = 0.
REQ-023 READ_TIMEOUT = 16, rwds_i held 00 -> after 16 XFER clocks, valid = err = 1 for one cycle, dat_o = 0, cs_n = 1.
REQ-024 rrq = wrq = 1 same cycle -> only the write executes; no valid pulse.
REQ-025 Macro defined: rwds_i = 00 during CA -> 3 LAT clocks; rwds_i = 01 -> 9 LAT clocks.
REQ-026 hbus_rst asserted in LAT -> next cycle cs_n = 1, all oe = 0, no valid; ready = 1 after release.
